mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between the instruction-fetch requester and the LSU data requester.
//  Sequences one outstanding transaction at a time through a req/gnt/rvalid handshake.
//  Generates the pipeline hold signals consumed by the decode pipe register:
//  stall_mem (fetch waiting), arb_eqmem (data owns the port) and memOp_done (data op complete).
//  Data has priority; a starvation counter guarantees fetch forward progress.
// PARAMETERS
//  AW            32  address width
//  DW            32  data width
//  STARVE_LIMIT  4   consecutive data grants with fetch pending before fetch is forced
// PORTS
//  clk          in   1     clock, all logic on posedge
//  rst          in   1     synchronous reset, active-high
//  if_req       in   1     fetch request; held until if_done
//  if_addr      in   AW    fetch address
//  if_flush     in   1     kill the in-flight fetch response (branch/exception redirect)
//  if_done      out  1     1-cycle pulse: if_rdata valid
//  if_rdata     out  DW    fetched word
//  d_req        in   1     data request; held until memOp_done
//  d_we         in   1     1 = store, 0 = load
//  d_addr       in   AW    data address
//  d_wdata      in   DW    store data
//  d_be         in   4     byte enables
//  memOp_done   out  1     1-cycle pulse: data op complete, d_rdata valid for loads
//  d_rdata      out  DW    load data
//  arb_eqmem    out  1     data transaction owns the port
//  stall_mem    out  1     fetch request pending, not yet done
//  mem_req      out  1     memory request
//  mem_we       out  1     memory write enable
//  mem_addr     out  AW    memory address
//  mem_wdata    out  DW    memory write data
//  mem_be       out  4     memory byte enables (4'hF for fetch)
//  mem_gnt      in   1     memory accepted request
//  mem_rvalid   in   1     memory response/ack (loads, stores and fetches)
//  mem_rdata    in   DW    memory read data
// BEHAVIOUR
//  - Reset: state=IDLE; starve_cnt=0; kill=0; all outputs 0 except stall_mem = if_req & ~if_done.
//  - FSM states: IDLE, D_REQ, D_WAIT, F_REQ, F_WAIT.
//  - IDLE arbitration:
//    - d_req & (~if_req | starve_cnt<STARVE_LIMIT) -> D_REQ;
//    - else if_req -> F_REQ.
//    - On the transition, latch addr/wdata/be/we into the request registers.
//  - *_REQ: mem_req=1, driven from the latched registers.
//    - mem_gnt -> *_WAIT.
//    - If mem_gnt & mem_rvalid occur in the same cycle, the transaction completes directly (state -> IDLE).
//  - *_WAIT: mem_req=0. mem_rvalid -> IDLE.
//  - mem_rvalid is ignored in IDLE and in any *_REQ state without mem_gnt.
//  - Completion:
//    - mem_rdata is registered into d_rdata/if_rdata.
//    - memOp_done/if_done pulses in the cycle after mem_rvalid, with the FSM back in IDLE.
//    - Min latency req->done = 3 cycles (IDLE, REQ with gnt, WAIT with rvalid, done).
//  - A requester may re-request in the done cycle. It is arbitrated in IDLE on the next cycle.
//    - The arbiter never issues a back-to-back grant to the same requester in its done cycle.
//  - arb_eqmem = (state in {D_REQ, D_WAIT}) | memOp_done. High through the done cycle inclusive.
//  - stall_mem = if_req & ~if_done (combinational).
//  - starve_cnt:
//    - +1 on each data grant (IDLE->D_REQ) while if_req=1, saturating at STARVE_LIMIT.
//    - Cleared on a fetch grant or whenever if_req=0.
//  - if_flush:
//    - In F_REQ/F_WAIT, or in the cycle of IDLE->F_REQ: sets kill. The transaction still completes on the bus
//      (mem_req is never withdrawn before gnt). if_done is suppressed, and kill clears at completion.
//    - In IDLE with no fetch grant, or in data states: no effect.
//  - A flush coincident with mem_rvalid in F_WAIT suppresses that if_done.
//  - Requests are never dropped. A d_req arriving during a fetch waits in IDLE for the next arbitration.
//  - rst mid-transaction: immediate return to IDLE. Any subsequent stale mem_rvalid is ignored.
// TESTING
//  - Load only:
//    - Stimulus: d_req=1, we=0, addr=0x100; gnt immediate; rvalid 2 cycles later with rdata=0xDEADBEEF.
//    - Response: memOp_done 1 pulse with d_rdata=0xDEADBEEF; arb_eqmem high from D_REQ through done.
//  - Contention: if_req and d_req asserted in the same cycle -> data granted first; stall_mem stays 1
//    until the fetch if_done.
//  - Starvation:
//    - Stimulus: d_req held continuously with if_req=1.
//    - Response: exactly 4 data transactions, then a fetch grant; starve_cnt returns to 0.
//  - Flush:
//    - Stimulus: if_flush pulsed during F_WAIT.
//    - Response: the bus completes, if_done stays 0, and the next if_req completes normally
//      with correct if_rdata.
//  - Zero-wait: gnt and rvalid in the same REQ cycle -> done pulses the next cycle; no extra memory request.
//  - Reset: rst during D_WAIT, then rvalid arrives -> memOp_done=0, mem_req=0, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and LSU data, one outstanding
// req/gnt/rvalid transaction at a time, data-priority with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_be,
    output logic          memOp_done,
    output logic [DW-1:0] d_rdata,
    output logic          arb_eqmem,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, F_REQ, F_WAIT} state_t;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t          state_reg, state_next;
    logic [CW-1:0]   starve_cnt_reg, starve_cnt_next;
    logic            kill_reg, kill_next;
    logic            req_we_reg;
    logic [AW-1:0]   req_addr_reg;
    logic [DW-1:0]   req_wdata_reg;
    logic [3:0]      req_be_reg;
    logic            d_done_reg, f_done_reg;
    logic [DW-1:0]   d_rdata_reg, if_rdata_reg;

    logic in_data, in_fetch, req_phase, wait_phase, bus_done;
    logic d_complete, f_complete, f_deliver;
    logic arb_idle, d_win, f_win;

    assign in_data    = (state_reg == D_REQ) || (state_reg == D_WAIT);
    assign in_fetch   = (state_reg == F_REQ) || (state_reg == F_WAIT);
    assign req_phase  = (state_reg == D_REQ) || (state_reg == F_REQ);
    assign wait_phase = (state_reg == D_WAIT) || (state_reg == F_WAIT);
    assign bus_done   = (req_phase & mem_gnt & mem_rvalid) | (wait_phase & mem_rvalid);
    assign d_complete = bus_done & in_data;
    assign f_complete = bus_done & in_fetch;
    assign f_deliver  = f_complete & ~kill_reg & ~if_flush;

    // No grant in a done cycle: the finished requester's req is still the old one.
    assign arb_idle = (state_reg == IDLE) & ~d_done_reg & ~f_done_reg;
    assign d_win    = arb_idle & d_req & (~if_req | (starve_cnt_reg < LIMIT));
    assign f_win    = arb_idle & if_req & ~d_win;

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        kill_next       = kill_reg;
        case (state_reg)
            IDLE: begin
                if (d_win)      state_next = D_REQ;
                else if (f_win) state_next = F_REQ;
            end
            D_REQ:  if (mem_gnt) state_next = mem_rvalid ? IDLE : D_WAIT;
            D_WAIT: if (mem_rvalid) state_next = IDLE;
            F_REQ:  if (mem_gnt) state_next = mem_rvalid ? IDLE : F_WAIT;
            F_WAIT: if (mem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (!if_req || f_win)
            starve_cnt_next = '0;
        else if (d_win && (starve_cnt_reg < LIMIT))
            starve_cnt_next = starve_cnt_reg + CW'(1);

        // A flush marks the in-flight (or just-granted) fetch; the bus still completes.
        if (f_complete)
            kill_next = 1'b0;
        else if (if_flush && (in_fetch || f_win))
            kill_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            kill_reg       <= 1'b0;
            req_we_reg     <= 1'b0;
            req_addr_reg   <= '0;
            req_wdata_reg  <= '0;
            req_be_reg     <= '0;
            d_done_reg     <= 1'b0;
            f_done_reg     <= 1'b0;
            d_rdata_reg    <= '0;
            if_rdata_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            kill_reg       <= kill_next;
            if (d_win) begin
                req_we_reg    <= d_we;
                req_addr_reg  <= d_addr;
                req_wdata_reg <= d_wdata;
                req_be_reg    <= d_be;
            end else if (f_win) begin
                req_we_reg    <= 1'b0;
                req_addr_reg  <= if_addr;
                req_wdata_reg <= '0;
                req_be_reg    <= 4'hF;
            end
            d_done_reg <= d_complete;
            f_done_reg <= f_deliver;
            if (d_complete) d_rdata_reg <= mem_rdata;
            if (f_deliver)  if_rdata_reg <= mem_rdata;
        end
    end

    assign mem_req    = req_phase;
    assign mem_we     = req_phase & req_we_reg;
    assign mem_addr   = req_addr_reg;
    assign mem_wdata  = req_wdata_reg;
    assign mem_be     = req_be_reg;
    assign memOp_done = d_done_reg;
    assign d_rdata    = d_rdata_reg;
    assign if_done    = f_done_reg;
    assign if_rdata   = if_rdata_reg;
    assign arb_eqmem  = in_data | d_done_reg;
    assign stall_mem  = if_req & ~f_done_reg;

endmodule
